// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encoding for the multi-cycle ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_NOT  = 4'b1010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mc_if.sv
// Operand and result handshake bundle of the multi-cycle ALU.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the ALU, out_ready from the consumer.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_flag;
  logic             overflow_flag;
  logic             zero_flag;
  logic             negative_flag;
  logic             div_by_zero;

  // Issue/consumer side
  modport master (
    output in_valid, a, b, select, out_ready,
    input  in_ready, out_valid, result, result_hi,
           carry_flag, overflow_flag, zero_flag, negative_flag, div_by_zero
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, select, out_ready,
    output in_ready, out_valid, result, result_hi,
           carry_flag, overflow_flag, zero_flag, negative_flag, div_by_zero
  );
endinterface

// File: rtl/alu_div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Latency: start edge loads operands, then WIDTH iterations; done is high during the last one.
// Backpressure: none; the caller only starts it when idle and must take the result on done.
module alu_div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_sub;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Shift the next dividend bit into the partial remainder; bit WIDTH of the
  // difference is the borrow, since the true difference is always < divisor.
  assign w_trial   = {r_rem, r_q[WIDTH-1]};
  assign w_sub     = w_trial - {1'b0, r_dvs};
  assign w_fits    = ~w_sub[WIDTH];
  assign w_rem_nxt = w_fits ? w_sub[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_nxt   = {r_q[WIDTH-2:0], w_fits};

  // Outputs are the values being produced by the current iteration so the
  // caller can capture them on the same edge that finishes the division.
  assign done      = (r_cnt == CW'(1));
  assign quotient  = w_q_nxt;
  assign remainder = w_rem_nxt;

  // Load operands on start, otherwise step one bit while iterations remain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_q   <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (start) begin
      r_cnt <= CW'(WIDTH);
      r_q   <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      r_q   <= w_q_nxt;
      r_rem <= w_rem_nxt;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result/flags and valid/ready on both sides.
// Latency: 1 cycle for every op except DIV with nonzero divisor (WIDTH+1 cycles).
// Backpressure: in_ready low while dividing or while a held result is not being taken.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     reset,
  alu_mc_if.slave bus
);
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic               w_carry;
  logic               w_ovf;
  logic               w_dbz;
  logic               w_in_ready;
  logic               w_fire;
  logic               w_div_start;
  logic               w_div_done;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  state_t             r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_carry;
  logic               r_ovf;
  logic               r_zero;
  logic               r_neg;
  logic               r_dbz;

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  // Single-cycle op mux; DIV by zero is resolved here, real divides go to the divider
  always_comb begin
    w_lo    = '0;
    w_hi    = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_dbz   = 1'b0;
    case (bus.select)
      OP_ADD: begin
        w_lo    = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_lo    = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];
        w_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_MUL: begin
        w_lo    = w_prod[WIDTH-1:0];
        w_hi    = w_prod[2*WIDTH-1:WIDTH];
        w_carry = |w_prod[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (bus.b == '0) begin
          w_hi  = bus.a;
          w_dbz = 1'b1;
        end
      end
      OP_AND:  w_lo = bus.a & bus.b;
      OP_OR:   w_lo = bus.a | bus.b;
      OP_NAND: w_lo = ~(bus.a & bus.b);
      OP_NOR:  w_lo = ~(bus.a | bus.b);
      OP_XOR:  w_lo = bus.a ^ bus.b;
      OP_XNOR: w_lo = ~(bus.a ^ bus.b);
      OP_NOT:  w_lo = ~bus.a;
      default: ;
    endcase
  end

  assign w_in_ready  = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_fire      = bus.in_valid && w_in_ready;
  assign w_div_start = w_fire && (bus.select == OP_DIV) && (bus.b != '0);

  alu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (w_div_start),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // Handshake FSM and output register; a load in the same cycle as a pop wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_div_start) begin
            r_state <= ST_BUSY;
          end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_result    <= w_lo;
            r_result_hi <= w_hi;
            r_carry     <= w_carry;
            r_ovf       <= w_ovf;
            r_zero      <= (w_lo == '0);
            r_neg       <= w_lo[WIDTH-1];
            r_dbz       <= w_dbz;
          end
        end
        ST_BUSY: begin
          if (w_div_done) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b1;
            r_result    <= w_quo;
            r_result_hi <= w_rem;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= (w_quo == '0);
            r_neg       <= w_quo[WIDTH-1];
            r_dbz       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.result        = r_result;
  assign bus.result_hi     = r_result_hi;
  assign bus.carry_flag    = r_carry;
  assign bus.overflow_flag = r_ovf;
  assign bus.zero_flag     = r_zero;
  assign bus.negative_flag = r_neg;
  assign bus.div_by_zero   = r_dbz;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): directed spec vectors, stall, reset mid-divide, random traffic.
// Expected results come from a plain-arithmetic reference model plus a latency/occupancy tracker.
// Outputs checked at the falling edge; in_ready checked 1 time unit after inputs change.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
    logic       d;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;

  // Model state: held output, whether it is valid, and remaining divide cycles
  bit   m_ov   = 1'b0;
  int   m_busy = 0;
  exp_t m_out  = '0;
  exp_t m_pend = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference semantics from integer arithmetic
  function automatic exp_t ref_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    exp_t e;
    int ua, ub, sa, sb, r;
    e  = '0;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      OP_ADD: begin
        r    = ua + ub;
        e.lo = 8'(r);
        e.c  = (r > 255);
        e.v  = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      OP_SUB: begin
        r    = ua - ub;
        e.lo = 8'(r);
        e.c  = (ua < ub);
        e.v  = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      OP_MUL: begin
        r    = ua * ub;
        e.lo = 8'(r);
        e.hi = 8'(r / 256);
        e.c  = (r > 255);
      end
      OP_DIV: begin
        if (ub == 0) begin
          e.hi = a;
          e.d  = 1'b1;
        end else begin
          e.lo = 8'(ua / ub);
          e.hi = 8'(ua % ub);
        end
      end
      OP_AND:  e.lo = a & b;
      OP_OR:   e.lo = a | b;
      OP_NAND: e.lo = ~(a & b);
      OP_NOR:  e.lo = ~(a | b);
      OP_XOR:  e.lo = a ^ b;
      OP_XNOR: e.lo = ~(a ^ b);
      OP_NOT:  e.lo = ~a;
      default: ;
    endcase
    e.z = (e.lo == 8'h00);
    e.n = e.lo[7];
    return e;
  endfunction

  // One clock cycle, entered and left at a falling edge
  task automatic cycle(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [3:0] isel, input bit ordy);
    bit   exp_rdy;
    exp_t e;
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("result_hi_lo", 32'({bus.result_hi, bus.result}), 32'({m_out.hi, m_out.lo}));
    chk("flags_cvznd",
        32'({bus.carry_flag, bus.overflow_flag, bus.zero_flag, bus.negative_flag, bus.div_by_zero}),
        32'({m_out.c, m_out.v, m_out.z, m_out.n, m_out.d}));
    bus.in_valid  = iv;
    bus.a         = ia;
    bus.b         = ib;
    bus.select    = isel;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (m_busy == 0) && (!m_ov || ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (m_ov && ordy) m_ov = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_out = m_pend;
        m_ov  = 1'b1;
      end
    end else if (iv && exp_rdy) begin
      e = ref_op(ia, ib, isel);
      if (isel == OP_DIV && ib != 8'h00) begin
        m_busy = W;
        m_pend = e;
      end else begin
        m_out = e;
        m_ov  = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.select    = '0;
    bus.out_ready = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'({bus.result_hi, bus.result}), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;

    // Pin the reference model with hand-computed values: {lo, c, v, z, n}
    e = ref_op(8'h7F, 8'h01, OP_ADD);
    chk("pin_add_ovf", 32'({e.lo, e.c, e.v, e.z, e.n}), 32'({8'h80, 4'b0101}));
    e = ref_op(8'h03, 8'h05, OP_SUB);
    chk("pin_sub_borrow", 32'({e.lo, e.c, e.v, e.z, e.n}), 32'({8'hFE, 4'b1001}));
    e = ref_op(8'hFF, 8'h01, OP_ADD);
    chk("pin_add_carry", 32'({e.lo, e.c, e.v, e.z, e.n}), 32'({8'h00, 4'b1010}));
    e = ref_op(8'hFF, 8'hFF, OP_MUL);
    chk("pin_mul", 32'({e.hi, e.lo, e.c}), 32'({16'hFE01, 1'b1}));
    e = ref_op(8'd200, 8'd7, OP_DIV);
    chk("pin_div", 32'({e.hi, e.lo, e.d}), 32'({8'd4, 8'd28, 1'b0}));
    e = ref_op(8'h55, 8'h00, OP_DIV);
    chk("pin_div0", 32'({e.hi, e.lo, e.d, e.z}), 32'({8'h55, 8'h00, 2'b11}));

    // Directed spec vectors, back to back with out_ready held high
    cycle(1'b1, 8'h7F, 8'h01, OP_ADD, 1'b1);
    cycle(1'b1, 8'h03, 8'h05, OP_SUB, 1'b1);
    cycle(1'b1, 8'hFF, 8'h01, OP_ADD, 1'b1);
    cycle(1'b1, 8'hFF, 8'hFF, OP_MUL, 1'b1);
    cycle(1'b1, 8'h55, 8'h00, OP_DIV, 1'b1);
    cycle(1'b1, 8'hA5, 8'h3C, 4'b1111, 1'b1);
    cycle(1'b1, 8'd200, 8'd7, OP_DIV, 1'b1);
    // Offers during the divide must be refused
    for (int k = 0; k < W; k++) cycle(1'b1, 8'hAA, 8'h11, OP_ADD, 1'b1);
    chk("div_latency_valid", 32'(bus.out_valid), 32'd1);
    chk("div_q_r", 32'({bus.result_hi, bus.result}), 32'h041C);
    cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);

    // Consumer stalls for 5 cycles with a result pending
    cycle(1'b1, 8'h12, 8'h34, OP_ADD, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'($urandom), 8'($urandom), OP_OR, 1'b0);
    chk("stall_hold", 32'({bus.out_valid, bus.result_hi, bus.result}), 32'h10046);
    cycle(1'b1, 8'h0F, 8'hF3, OP_AND, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);

    // Reset in the middle of a divide
    cycle(1'b1, 8'hC8, 8'd3, OP_DIV, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", 32'({bus.result_hi, bus.result}), 32'd0);
    chk("midrst_flags",
        32'({bus.carry_flag, bus.overflow_flag, bus.zero_flag, bus.negative_flag, bus.div_by_zero}),
        32'd0);
    m_ov   = 1'b0;
    m_busy = 0;
    m_out  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 8'h10, 8'h20, OP_ADD, 1'b1);
    chk("post_rst_add", 32'({bus.out_valid, bus.result}), 32'h130);
    cycle(1'b1, 8'd100, 8'd9, OP_DIV, 1'b1);
    for (int k = 0; k < W + 1; k++) cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [3:0] rop;
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      rop = ($urandom_range(0, 3) == 0) ? OP_DIV : 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) < 7, ra, rb, rop, $urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < W + 2; k++) cycle(1'b0, 8'h00, 8'h00, OP_ADD, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
